// File: rtl/ifft_frame_arb.sv
`default_nettype none
// ============================================================================
// Module  : ifft_frame_arb
// Brief   : Frame-level round-robin arbiter sharing one IFFT/reorder chain
//           between the DCT (0) and IDCT (1) paths; routes returns by tag.
// Rev     : 1.0  initial release
// ============================================================================
module ifft_frame_arb #(
    parameter int wDataInOut = 16,
    parameter int TAG_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          rst_n_sync,
    input  logic [1:0]                    req_valid,
    output logic [1:0]                    req_ready,
    input  logic [1:0]                    req_sop,
    input  logic [1:0]                    req_eop,
    input  logic [2*wDataInOut-1:0]       req_real,
    input  logic [2*wDataInOut-1:0]       req_imag,
    input  logic [2*12-1:0]               req_fftpts,
    output logic                          dn_valid,
    output logic                          dn_sop,
    output logic                          dn_eop,
    output logic [wDataInOut-1:0]         dn_real,
    output logic [wDataInOut-1:0]         dn_imag,
    output logic [11:0]                   dn_fftpts,
    input  logic                          dn_ready,
    input  logic                          up_valid,
    input  logic                          up_sop,
    input  logic                          up_eop,
    input  logic [wDataInOut-1:0]         up_real,
    input  logic [wDataInOut-1:0]         up_imag,
    output logic                          up_ready,
    output logic [1:0]                    rsp_valid,
    output logic [1:0]                    rsp_sop,
    output logic [1:0]                    rsp_eop,
    output logic [wDataInOut-1:0]         rsp_real,
    output logic [wDataInOut-1:0]         rsp_imag,
    input  logic [1:0]                    rsp_ready,
    output logic [$clog2(TAG_DEPTH):0]    frames_inflight,
    output logic                          err_stray
);

    localparam int               PTR_W    = $clog2(TAG_DEPTH);
    localparam logic [PTR_W:0]   TAG_FULL = TAG_DEPTH[PTR_W:0];
    localparam logic [0:0]       S_IDLE   = 1'b0;
    localparam logic [0:0]       S_XFER   = 1'b1;

    logic [0:0]        state;
    logic [0:0]        state_nxt;
    logic              gnt;
    logic              last_grant;
    logic [1:0]        cand;
    logic              fifo_full;
    logic              fifo_empty;
    logic              grant_en;
    logic              grant_sel;
    logic              xfer_done;
    logic              tag_mem [TAG_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              head;
    logic              pop;

    // Full test uses registered occupancy: a same-cycle pop never unblocks a grant.
    assign cand       = req_valid & req_sop;
    assign fifo_full  = (frames_inflight == TAG_FULL);
    assign fifo_empty = (frames_inflight == '0);
    assign grant_en   = (state == S_IDLE) && (cand != 2'b00) && !fifo_full;
    assign grant_sel  = (cand == 2'b11) ? ~last_grant : cand[1];
    assign xfer_done  = (state == S_XFER) && dn_valid && dn_ready && dn_eop;

    always_ff @(posedge clk) begin
        if (!rst_n_sync) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (grant_en)  state_nxt = S_XFER;
            S_XFER:  if (xfer_done) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        dn_valid  = 1'b0;
        dn_sop    = 1'b0;
        dn_eop    = 1'b0;
        dn_real   = '0;
        dn_imag   = '0;
        req_ready = 2'b00;
        case (state)
            // Stray mid-frame beats are drained; sop beats wait for the grant.
            S_IDLE: req_ready = req_valid & ~req_sop;
            S_XFER: begin
                dn_valid       = req_valid[gnt];
                dn_sop         = req_sop[gnt];
                dn_eop         = req_eop[gnt];
                dn_real        = gnt ? req_real[2*wDataInOut-1:wDataInOut]
                                     : req_real[wDataInOut-1:0];
                dn_imag        = gnt ? req_imag[2*wDataInOut-1:wDataInOut]
                                     : req_imag[wDataInOut-1:0];
                req_ready[gnt] = dn_ready;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n_sync) begin
            gnt        <= 1'b0;
            last_grant <= 1'b1;
            dn_fftpts  <= '0;
        end else if (grant_en) begin
            gnt        <= grant_sel;
            last_grant <= grant_sel;
            dn_fftpts  <= grant_sel ? req_fftpts[23:12] : req_fftpts[11:0];
        end
    end

    always_ff @(posedge clk) begin
        if (grant_en) begin
            tag_mem[wr_ptr] <= grant_sel;
        end
    end

    assign head = tag_mem[rd_ptr];
    assign pop  = !fifo_empty && up_valid && up_ready && up_eop;

    always_ff @(posedge clk) begin
        if (!rst_n_sync) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            frames_inflight <= '0;
            err_stray       <= 1'b0;
        end else begin
            if (grant_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)      rd_ptr <= rd_ptr + 1'b1;
            if (grant_en && !pop)      frames_inflight <= frames_inflight + 1'b1;
            else if (pop && !grant_en) frames_inflight <= frames_inflight - 1'b1;
            if (fifo_empty && up_valid) err_stray <= 1'b1;
        end
    end

    // Return path is purely combinational; with no owner on record beats are sunk.
    always_comb begin
        rsp_valid = 2'b00;
        rsp_sop   = 2'b00;
        rsp_eop   = 2'b00;
        up_ready  = 1'b1;
        if (!fifo_empty) begin
            rsp_valid[head] = up_valid;
            rsp_sop[head]   = up_sop;
            rsp_eop[head]   = up_eop;
            up_ready        = rsp_ready[head];
        end
    end

    assign rsp_real = up_real;
    assign rsp_imag = up_imag;

endmodule
`default_nettype wire

// File: tb/tb_ifft_frame_arb.sv
`default_nettype none
// ============================================================================
// Module  : tb_ifft_frame_arb
// Brief   : Directed self-checking bench for the IFFT frame arbiter.
// Rev     : 1.0  initial release
// ============================================================================
module tb_ifft_frame_arb;

    localparam int W   = 16;
    localparam int TD  = 4;
    localparam int TMO = 200;

    logic          clk = 1'b0;
    logic          rst_n_sync;
    logic [1:0]    req_valid, req_ready, req_sop, req_eop;
    logic [2*W-1:0] req_real, req_imag;
    logic [23:0]   req_fftpts;
    logic          dn_valid, dn_sop, dn_eop, dn_ready;
    logic [W-1:0]  dn_real, dn_imag;
    logic [11:0]   dn_fftpts;
    logic          up_valid, up_sop, up_eop, up_ready;
    logic [W-1:0]  up_real, up_imag;
    logic [1:0]    rsp_valid, rsp_sop, rsp_eop, rsp_ready;
    logic [W-1:0]  rsp_real, rsp_imag;
    logic [2:0]    frames_inflight;
    logic          err_stray;

    always #5 clk = ~clk;

    ifft_frame_arb #(.wDataInOut(W), .TAG_DEPTH(TD)) dut (
        .clk(clk), .rst_n_sync(rst_n_sync),
        .req_valid(req_valid), .req_ready(req_ready), .req_sop(req_sop), .req_eop(req_eop),
        .req_real(req_real), .req_imag(req_imag), .req_fftpts(req_fftpts),
        .dn_valid(dn_valid), .dn_sop(dn_sop), .dn_eop(dn_eop),
        .dn_real(dn_real), .dn_imag(dn_imag), .dn_fftpts(dn_fftpts), .dn_ready(dn_ready),
        .up_valid(up_valid), .up_sop(up_sop), .up_eop(up_eop),
        .up_real(up_real), .up_imag(up_imag), .up_ready(up_ready),
        .rsp_valid(rsp_valid), .rsp_sop(rsp_sop), .rsp_eop(rsp_eop),
        .rsp_real(rsp_real), .rsp_imag(rsp_imag), .rsp_ready(rsp_ready),
        .frames_inflight(frames_inflight), .err_stray(err_stray)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int bad;
    int t;
    logic [31:0] exp_q[$];
    logic [31:0] dn_q[$];
    logic [11:0] pts_q[$];
    int          gap_q[$];
    int          gap_cnt;
    bit          gap_on;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Beat payload encodes requester, frame and beat index.
    function automatic logic [15:0] mk(input int r, input int f, input int b);
        return 16'((r << 14) | (f << 8) | b);
    endfunction

    always @(negedge clk) begin
        if (!rst_n_sync) begin
            gap_on = 1'b0;
        end else begin
            if (dn_valid && dn_sop && gap_on) begin
                gap_q.push_back(gap_cnt);
                gap_on = 1'b0;
            end
            if (dn_valid && dn_ready) begin
                dn_q.push_back({dn_imag, dn_real});
                if (dn_sop) pts_q.push_back(dn_fftpts);
                if (dn_eop) begin
                    gap_on  = 1'b1;
                    gap_cnt = 0;
                end
            end else if (gap_on && !dn_valid) begin
                gap_cnt++;
            end
        end
    end

    task automatic clear_mon();
        dn_q.delete(); pts_q.delete(); gap_q.delete(); exp_q.delete();
    endtask

    task automatic add_exp(input int r, input int f, input int nb);
        for (int b = 0; b < nb; b++) exp_q.push_back({~mk(r, f, b), mk(r, f, b)});
    endtask

    task automatic check_stream(input string tag);
        int nbad = 0;
        check({tag, "_len"}, dn_q.size(), exp_q.size());
        foreach (exp_q[i]) if (i >= dn_q.size() || dn_q[i] !== exp_q[i]) nbad++;
        check({tag, "_data_bad"}, nbad, 0);
    endtask

    task automatic do_reset();
        rst_n_sync = 1'b0;
        req_valid = '0; req_sop = '0; req_eop = '0;
        req_real = '0; req_imag = '0; req_fftpts = '0;
        dn_ready = 1'b1;
        up_valid = 1'b0; up_sop = 1'b0; up_eop = 1'b0; up_real = '0; up_imag = '0;
        rsp_ready = 2'b11;
        repeat (3) @(posedge clk);
        #1 rst_n_sync = 1'b1;
        @(negedge clk);
        check("rst_dn_valid", dn_valid, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_inflight", frames_inflight, 0);
        check("rst_err_stray", err_stray, 0);
        check("rst_fftpts", dn_fftpts, 0);
        check("rst_up_ready", up_ready, 1);
        @(posedge clk); #1;
    endtask

    task automatic send_frames(input int r, input int nfr, input int nb, input int pts);
        bit acc;
        int tt;
        for (int f = 0; f < nfr; f++) begin
            for (int b = 0; b < nb; b++) begin
                req_valid[r] = 1'b1;
                req_sop[r]   = (b == 0);
                req_eop[r]   = (b == nb - 1);
                req_real[r*W +: W] = mk(r, f, b);
                req_imag[r*W +: W] = ~mk(r, f, b);
                req_fftpts[r*12 +: 12] = 12'(pts);
                acc = 1'b0;
                tt  = 0;
                while (!acc && tt < TMO) begin
                    @(negedge clk);
                    acc = req_ready[r];
                    @(posedge clk); #1;
                    tt++;
                end
                if (!acc) begin
                    check($sformatf("drv%0d_timeout", r), {31'b0, acc}, 1);
                    return;
                end
            end
        end
        req_valid[r] = 1'b0;
        req_sop[r]   = 1'b0;
        req_eop[r]   = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        // Single 32-point frame from requester 0, then its return.
        do_reset();
        clear_mon();
        fork
            send_frames(0, 1, 32, 32);
            begin : t1_lat
                @(negedge clk);
                check("t1_idle_dn_valid", dn_valid, 0);
                check("t1_sop_not_consumed", req_ready, 2'b00);
                @(negedge clk);
                check("t1_first_dn_valid", dn_valid, 1);
                check("t1_first_sop", dn_sop, 1);
                check("t1_first_real", dn_real, mk(0, 0, 0));
                check("t1_inflight", frames_inflight, 1);
                check("t1_fftpts", dn_fftpts, 32);
            end
        join
        add_exp(0, 0, 32);
        check_stream("t1");
        @(negedge clk);
        check("t1_dn_idle", dn_valid, 0);
        check("t1_fftpts_hold", dn_fftpts, 32);
        @(posedge clk); #1;
        bad = 0;
        for (int b = 0; b < 32; b++) begin
            up_valid = 1'b1; up_sop = (b == 0); up_eop = (b == 31);
            up_real = 16'(16'h0100 + b); up_imag = ~up_real;
            @(negedge clk);
            if (rsp_valid !== 2'b01 || rsp_sop !== {1'b0, up_sop} || rsp_eop !== {1'b0, up_eop}
                || rsp_real !== up_real || rsp_imag !== up_imag || up_ready !== 1'b1) bad++;
            @(posedge clk); #1;
        end
        up_valid = 1'b0; up_sop = 1'b0; up_eop = 1'b0;
        check("t1_rsp_beats_bad", bad, 0);
        @(negedge clk);
        check("t1_inflight_zero", frames_inflight, 0);
        check("t1_no_stray", err_stray, 0);
        @(posedge clk); #1;

        // Tie after reset: grants alternate 0,1,0,1 with one idle cycle between.
        do_reset();
        clear_mon();
        fork
            send_frames(0, 2, 64, 64);
            send_frames(1, 2, 64, 64);
        join
        add_exp(0, 0, 64); add_exp(1, 0, 64); add_exp(0, 1, 64); add_exp(1, 1, 64);
        check_stream("t2");
        check("t2_pts_n", pts_q.size(), 4);
        bad = 0;
        foreach (pts_q[i]) if (pts_q[i] !== 12'd64) bad++;
        check("t2_pts_bad", bad, 0);
        check("t2_gap_n", gap_q.size(), 3);
        foreach (gap_q[i]) check($sformatf("t2_gap%0d", i), gap_q[i], 1);
        check("t2_inflight", frames_inflight, 4);

        // Backpressure: dn_ready toggles every cycle.
        do_reset();
        clear_mon();
        bad = 0;
        fork
            send_frames(0, 1, 8, 16);
            send_frames(1, 1, 8, 16);
            begin : t3_bp
                int r;
                for (int c = 0; c < 60; c++) begin
                    dn_ready = (c % 2 == 0);
                    @(negedge clk);
                    if (dn_valid) begin
                        r = int'(dn_real[15:14]);
                        if (req_ready[r] !== dn_ready || req_ready[1-r] !== 1'b0) bad++;
                    end
                    @(posedge clk); #1;
                end
                dn_ready = 1'b1;
            end
        join
        check("t3_ready_bad", bad, 0);
        add_exp(0, 0, 8); add_exp(1, 0, 8);
        check_stream("t3");

        // Tag FIFO full: fifth sop waits until the cycle after the first return eop.
        do_reset();
        clear_mon();
        fork
            send_frames(0, 5, 2, 8);
            begin : t4_full
                t = 0;
                while (frames_inflight != 3'd4 && t < TMO) begin
                    @(posedge clk); #1;
                    t++;
                end
                check("t4_reach_full", frames_inflight, 4);
                repeat (4) @(posedge clk);
                #1;
                for (int c = 0; c < 3; c++) begin
                    @(negedge clk);
                    check("t4_blocked_dn_valid", dn_valid, 0);
                    check("t4_blocked_ready", req_ready, 2'b00);
                    @(posedge clk); #1;
                end
                up_valid = 1'b1; up_sop = 1'b1; up_eop = 1'b0; up_real = 16'h0AAA; up_imag = 16'h0555;
                @(negedge clk);
                check("t4_up_ready", up_ready, 1);
                check("t4_rsp_valid", rsp_valid, 2'b01);
                @(posedge clk); #1;
                up_sop = 1'b0; up_eop = 1'b1;
                @(negedge clk);
                check("t4_dn_at_pop", dn_valid, 0);
                @(posedge clk); #1;
                up_valid = 1'b0; up_eop = 1'b0;
                @(negedge clk);
                check("t4_no_grant_same_cycle", dn_valid, 0);
                check("t4_inflight_after_pop", frames_inflight, 3);
                @(posedge clk); #1;
                @(negedge clk);
                check("t4_fifth_dn_valid", dn_valid, 1);
                check("t4_fifth_real", dn_real, mk(0, 4, 0));
                check("t4_inflight_refill", frames_inflight, 4);
            end
        join

        // Return routing in grant order 1,0 with rsp[1] stalled.
        do_reset();
        clear_mon();
        fork
            send_frames(1, 1, 2, 8);
            begin : t5_late
                @(posedge clk); #1;
                send_frames(0, 1, 2, 8);
            end
        join
        add_exp(1, 0, 2); add_exp(0, 0, 2);
        check_stream("t5_fwd");
        rsp_ready = 2'b01;
        up_valid = 1'b1; up_sop = 1'b1; up_eop = 1'b0; up_real = 16'h0A00; up_imag = 16'h0B00;
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (up_ready !== 1'b0 || rsp_valid !== 2'b10) bad++;
            @(posedge clk); #1;
        end
        check("t5_hold_bad", bad, 0);
        rsp_ready = 2'b11;
        @(negedge clk);
        check("t5_up_ready_rel", up_ready, 1);
        check("t5_rsp1_sop", rsp_sop, 2'b10);
        @(posedge clk); #1;
        up_sop = 1'b0; up_eop = 1'b1; up_real = 16'h0A01;
        @(negedge clk);
        check("t5_rsp1_eop", rsp_eop, 2'b10);
        @(posedge clk); #1;
        up_sop = 1'b1; up_eop = 1'b0; up_real = 16'h0C00;
        @(negedge clk);
        check("t5_rsp0_valid", rsp_valid, 2'b01);
        check("t5_rsp0_real", rsp_real, 16'h0C00);
        @(posedge clk); #1;
        up_sop = 1'b0; up_eop = 1'b1;
        @(negedge clk);
        check("t5_rsp0_eop", rsp_eop, 2'b01);
        @(posedge clk); #1;
        up_valid = 1'b0; up_eop = 1'b0;
        @(negedge clk);
        check("t5_inflight0", frames_inflight, 0);
        check("t5_no_stray", err_stray, 0);
        @(posedge clk); #1;

        // Stray return beat and a junk non-sop request beat in idle.
        rsp_ready = 2'b00;
        up_valid = 1'b1; up_sop = 1'b1; up_eop = 1'b1;
        req_valid[0] = 1'b1; req_sop[0] = 1'b0; req_real[15:0] = 16'h1234;
        @(negedge clk);
        check("t6_up_ready", up_ready, 1);
        check("t6_rsp_valid", rsp_valid, 2'b00);
        check("t6_junk_ready", req_ready, 2'b01);
        check("t6_dn_valid", dn_valid, 0);
        check("t6_err_before", err_stray, 0);
        @(posedge clk); #1;
        up_valid = 1'b0; up_sop = 1'b0; up_eop = 1'b0; req_valid = 2'b00;
        @(negedge clk);
        check("t6_err_set", err_stray, 1);
        check("t6_dn_still_idle", dn_valid, 0);
        check("t6_inflight", frames_inflight, 0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("t6_err_sticky", err_stray, 1);
        @(posedge clk); #1;
        do_reset();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
